// File: rtl/inst_mem_responder_if.sv
// Instruction-fill bus between the cache memory port/loader and the responder.
// The signal names inside the interface keep the original port names.
interface inst_mem_responder_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  i_req;
  logic [ADDR_WIDTH-1:0] i_req_addr;
  logic                  o_ready;
  logic                  i_flush;
  logic                  o_valid;
  logic [DATA_WIDTH-1:0] o_data;
  logic [ADDR_WIDTH-1:0] o_addr;
  logic                  o_last;
  logic                  o_err;
  logic                  i_wr;
  logic [ADDR_WIDTH-1:0] i_wr_addr;
  logic [DATA_WIDTH-1:0] i_wr_data;

  modport master (
    output i_req, i_req_addr, i_flush, i_wr, i_wr_addr, i_wr_data,
    input  o_ready, o_valid, o_data, o_addr, o_last, o_err
  );

  modport slave (
    input  i_req, i_req_addr, i_flush, i_wr, i_wr_addr, i_wr_data,
    output o_ready, o_valid, o_data, o_addr, o_last, o_err
  );
endinterface

// File: rtl/inst_mem_responder.sv
// Instruction-cache line-fill responder: after a fixed latency it streams one block
// critical-word-first, wrapping inside the block, from a loader-preloaded word array.
module inst_mem_responder #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int BLOCK_WORDS = 4,
  parameter int MEM_WORDS   = 1024,
  parameter int LATENCY     = 2
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  inst_mem_responder_if.slave  bus
);

  localparam int OFF_W  = $clog2(BLOCK_WORDS);
  localparam int LOW_W  = OFF_W + 2;
  localparam int MIDX_W = $clog2(MEM_WORDS);
  localparam int CNT_W  = $clog2(LATENCY + 1) + 1;
  localparam int BEAT_W = OFF_W + 1;
  localparam logic [ADDR_WIDTH-1:0] LOW_MASK  = ADDR_WIDTH'((1 << LOW_W) - 1);
  localparam logic [ADDR_WIDTH-1:0] MEM_BYTES = ADDR_WIDTH'(MEM_WORDS * 4);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST} state_t;

  state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [OFF_W-1:0]      start_q, start_d;
  logic [CNT_W-1:0]      wcnt_q, wcnt_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic                  valid_q, valid_d;
  logic                  last_q, last_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  logic [OFF_W-1:0]      beat_idx;
  logic [ADDR_WIDTH-1:0] beat_addr;
  logic                  in_range;
  logic                  wait_done;
  logic [DATA_WIDTH-1:0] rd_word;

  // Index arithmetic is OFF_W wide so the beat sequence wraps inside the block.
  assign beat_idx  = start_q + beat_q[OFF_W-1:0];
  assign beat_addr = base_q + ADDR_WIDTH'({beat_idx, 2'b00});
  assign in_range  = beat_addr < MEM_BYTES;
  assign rd_word   = mem[beat_addr[MIDX_W+1:2]];
  assign wait_done = (int'(wcnt_q) + 1) >= LATENCY;

  always_ff @(posedge i_clock) begin
    if (bus.i_wr && (bus.i_wr_addr < MEM_BYTES)) begin
      mem[bus.i_wr_addr[MIDX_W+1:2]] <= bus.i_wr_data;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.i_req) begin
          state_d = (LATENCY > 0) ? S_WAIT : S_BURST;
        end
      end
      S_WAIT: begin
        if (bus.i_flush) begin
          state_d = S_IDLE;
        end else if (wait_done) begin
          state_d = S_BURST;
        end
      end
      S_BURST: begin
        if (bus.i_flush || last_q) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    base_d  = base_q;
    start_d = start_q;
    wcnt_d  = wcnt_q;
    beat_d  = beat_q;
    valid_d = valid_q;
    last_d  = last_q;
    err_d   = err_q;
    data_d  = data_q;
    addr_d  = addr_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.i_req) begin
          base_d  = bus.i_req_addr & ~LOW_MASK;
          start_d = bus.i_req_addr[LOW_W-1:2];
          wcnt_d  = '0;
          beat_d  = '0;
        end
      end
      S_WAIT: begin
        if (bus.i_flush) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          err_d   = 1'b0;
        end else if (!wait_done) begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      S_BURST: begin
        if (bus.i_flush || last_q) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          err_d   = 1'b0;
        end else begin
          valid_d = 1'b1;
          addr_d  = beat_addr;
          data_d  = in_range ? rd_word : '0;
          err_d   = !in_range;
          last_d  = (beat_q == BEAT_W'(BLOCK_WORDS - 1));
          beat_d  = beat_q + 1'b1;
        end
      end
      default: begin
        valid_d = 1'b0;
        last_d  = 1'b0;
        err_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      base_q  <= '0;
      start_q <= '0;
      wcnt_q  <= '0;
      beat_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
      addr_q  <= '0;
    end else begin
      base_q  <= base_d;
      start_q <= start_d;
      wcnt_q  <= wcnt_d;
      beat_q  <= beat_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      err_q   <= err_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
    end
  end

  assign bus.o_ready = (state_q == S_IDLE);
  assign bus.o_valid = valid_q;
  assign bus.o_last  = last_q;
  assign bus.o_err   = err_q;
  assign bus.o_data  = data_q;
  assign bus.o_addr  = addr_q;

endmodule

// File: tb/tb_inst_mem_responder.sv
// Directed bench for inst_mem_responder: one instance with LATENCY=2, one with LATENCY=0.
module tb_inst_mem_responder;

  logic clk;
  logic rst;
  int unsigned total;
  int unsigned bad;

  inst_mem_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) ba ();
  inst_mem_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bb ();

  inst_mem_responder #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .BLOCK_WORDS(4), .MEM_WORDS(1024), .LATENCY(2)
  ) dut_a (
    .i_clock(clk), .i_reset(rst), .bus(ba.slave)
  );

  inst_mem_responder #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .BLOCK_WORDS(4), .MEM_WORDS(1024), .LATENCY(0)
  ) dut_b (
    .i_clock(clk), .i_reset(rst), .bus(bb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr_both(input logic [31:0] a, input logic [31:0] d);
    ba.i_wr = 1'b1; ba.i_wr_addr = a; ba.i_wr_data = d;
    bb.i_wr = 1'b1; bb.i_wr_addr = a; bb.i_wr_data = d;
    tick();
    ba.i_wr = 1'b0;
    bb.i_wr = 1'b0;
  endtask

  // Full fill on the LATENCY=2 instance: accept, two idle edges, four beats, idle.
  task automatic burst_a(input string tag, input logic [31:0] req_addr,
                         input logic [31:0] ea [4], input logic [31:0] ed [4],
                         input logic eerr);
    ba.i_req = 1'b1; ba.i_req_addr = req_addr;
    tick();
    ba.i_req = 1'b0;
    chk({tag, "_ready_lo"}, 32'(ba.o_ready), 32'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk({tag, "_wait_valid"}, 32'(ba.o_valid), 32'd0);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      chk({tag, "_valid"}, 32'(ba.o_valid), 32'd1);
      chk({tag, "_addr"}, ba.o_addr, ea[k]);
      chk({tag, "_data"}, ba.o_data, ed[k]);
      chk({tag, "_last"}, 32'(ba.o_last), (k == 3) ? 32'd1 : 32'd0);
      chk({tag, "_err"}, 32'(ba.o_err), 32'(eerr));
      chk({tag, "_busy"}, 32'(ba.o_ready), 32'd0);
    end
    tick();
    chk({tag, "_end_valid"}, 32'(ba.o_valid), 32'd0);
    chk({tag, "_end_ready"}, 32'(ba.o_ready), 32'd1);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    ba.i_req = 1'b0; ba.i_req_addr = '0; ba.i_flush = 1'b0;
    ba.i_wr = 1'b0; ba.i_wr_addr = '0; ba.i_wr_data = '0;
    bb.i_req = 1'b0; bb.i_req_addr = '0; bb.i_flush = 1'b0;
    bb.i_wr = 1'b0; bb.i_wr_addr = '0; bb.i_wr_data = '0;

    #12;
    chk("rst_ready", 32'(ba.o_ready), 32'd1);
    chk("rst_valid", 32'(ba.o_valid), 32'd0);
    chk("rst_last", 32'(ba.o_last), 32'd0);
    chk("rst_err", 32'(ba.o_err), 32'd0);
    chk("rst_data", ba.o_data, 32'd0);
    chk("rst_addr", ba.o_addr, 32'd0);
    tick();
    rst = 1'b0;

    for (int i = 0; i < 8; i++) wr_both(32'(i * 4), 32'h100 + 32'(i));
    for (int i = 0; i < 4; i++) wr_both(32'hFF0 + 32'(i * 4), 32'hA00 + 32'(i));

    burst_a("fill0", 32'h0, '{32'h0, 32'h4, 32'h8, 32'hC},
            '{32'h100, 32'h101, 32'h102, 32'h103}, 1'b0);
    burst_a("wrap18", 32'h18, '{32'h18, 32'h1C, 32'h10, 32'h14},
            '{32'h106, 32'h107, 32'h104, 32'h105}, 1'b0);
    burst_a("top", 32'hFFC, '{32'hFFC, 32'hFF0, 32'hFF4, 32'hFF8},
            '{32'hA03, 32'hA00, 32'hA01, 32'hA02}, 1'b0);
    burst_a("oob", 32'h1000, '{32'h1000, 32'h1004, 32'h1008, 32'h100C},
            '{32'h0, 32'h0, 32'h0, 32'h0}, 1'b1);

    // Zero latency: first beat right after the edge following accept; mid-burst request ignored.
    bb.i_req = 1'b1; bb.i_req_addr = 32'h4;
    tick();
    bb.i_req = 1'b0;
    chk("lat0_ready_lo", 32'(bb.o_ready), 32'd0);
    tick();
    chk("lat0_b0_valid", 32'(bb.o_valid), 32'd1);
    chk("lat0_b0_addr", bb.o_addr, 32'h4);
    chk("lat0_b0_data", bb.o_data, 32'h101);
    bb.i_req = 1'b1; bb.i_req_addr = 32'h0;
    tick();
    bb.i_req = 1'b0;
    chk("lat0_b1_addr", bb.o_addr, 32'h8);
    chk("lat0_b1_ready", 32'(bb.o_ready), 32'd0);
    tick();
    chk("lat0_b2_addr", bb.o_addr, 32'hC);
    chk("lat0_b2_last", 32'(bb.o_last), 32'd0);
    tick();
    chk("lat0_b3_addr", bb.o_addr, 32'h0);
    chk("lat0_b3_data", bb.o_data, 32'h100);
    chk("lat0_b3_last", 32'(bb.o_last), 32'd1);
    tick();
    chk("lat0_end_valid", 32'(bb.o_valid), 32'd0);
    chk("lat0_end_ready", 32'(bb.o_ready), 32'd1);
    tick();
    chk("lat0_no_requeue", 32'(bb.o_valid), 32'd0);

    // Flush on the second beat.
    ba.i_req = 1'b1; ba.i_req_addr = 32'h0;
    tick();
    ba.i_req = 1'b0;
    tick(); tick(); tick();
    tick();
    chk("flush_b1_addr", ba.o_addr, 32'h4);
    ba.i_flush = 1'b1;
    tick();
    ba.i_flush = 1'b0;
    chk("flush_valid", 32'(ba.o_valid), 32'd0);
    chk("flush_last", 32'(ba.o_last), 32'd0);
    chk("flush_ready", 32'(ba.o_ready), 32'd1);
    burst_a("after_flush", 32'h8, '{32'h8, 32'hC, 32'h0, 32'h4},
            '{32'h102, 32'h103, 32'h100, 32'h101}, 1'b0);

    // Asynchronous reset in WAIT.
    ba.i_req = 1'b1; ba.i_req_addr = 32'h0;
    tick();
    ba.i_req = 1'b0;
    chk("rw_ready_lo", 32'(ba.o_ready), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("rw_ready", 32'(ba.o_ready), 32'd1);
    chk("rw_valid", 32'(ba.o_valid), 32'd0);
    #1 rst = 1'b0;
    tick();

    // Asynchronous reset on an error beat.
    ba.i_req = 1'b1; ba.i_req_addr = 32'h1000;
    tick();
    ba.i_req = 1'b0;
    tick(); tick(); tick();
    chk("rb_err_hi", 32'(ba.o_err), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rb_err", 32'(ba.o_err), 32'd0);
    chk("rb_valid", 32'(ba.o_valid), 32'd0);
    chk("rb_ready", 32'(ba.o_ready), 32'd1);
    #1 rst = 1'b0;
    tick();

    // Asynchronous reset on the last beat.
    ba.i_req = 1'b1; ba.i_req_addr = 32'h0;
    tick();
    ba.i_req = 1'b0;
    tick(); tick(); tick(); tick(); tick(); tick();
    chk("rl_last_hi", 32'(ba.o_last), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rl_last", 32'(ba.o_last), 32'd0);
    chk("rl_valid", 32'(ba.o_valid), 32'd0);
    chk("rl_ready", 32'(ba.o_ready), 32'd1);
    #1 rst = 1'b0;
    tick();

    wr_both(32'h0, 32'hDEAD);
    burst_a("loader", 32'h0, '{32'h0, 32'h4, 32'h8, 32'hC},
            '{32'hDEAD, 32'h101, 32'h102, 32'h103}, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inst_mem_responder.md
Name: inst_mem_responder

Overview:
Memory-side responder for instruction-cache line fills. It accepts one block-fill request at a time from the cache's memory port and waits a programmable access latency. It then streams the block back one instruction word per cycle, starting at the critical word and wrapping within the block. Backing storage is an internal word array, preloaded through a simple loader write port. The block sits between the instruction cache and the program memory/boot loader.

Parameters:
ADDR_WIDTH, 32, byte-address width; matches InstAddr.
DATA_WIDTH, 32, instruction word width; matches Inst.
BLOCK_WORDS, 4, words per cache block; power of two, 2..16.
MEM_WORDS, 1024, backing array depth in words.
LATENCY, 2, idle cycles between request accept and first beat; 0..15.

Ports:
i_clock  in  1  clock, rising edge.
i_reset  in  1  asynchronous reset, active-high.
i_req  in  1  fill request.
i_req_addr  in  ADDR_WIDTH  byte address of the missed instruction; bits[1:0] ignored.
o_ready  out  1  responder idle; a request is accepted when i_req & o_ready at a rising edge.
i_flush  in  1  abort the current fill.
o_valid  out  1  beat valid.
o_data  out  DATA_WIDTH  beat data.
o_addr  out  ADDR_WIDTH  byte address of the current beat (word-aligned).
o_last  out  1  final beat of the block.
o_err  out  1  beat address is outside the backing array.
i_wr  in  1  loader write enable.
i_wr_addr  in  ADDR_WIDTH  loader byte address.
i_wr_data  in  DATA_WIDTH  loader data.

Behaviour:
- Reset (asynchronous): state=IDLE; o_ready=1; o_valid=o_last=o_err=0; o_data=0; o_addr=0; counters=0. The array contents are not reset.
- States:
  - IDLE: o_ready=1. On accept, latch the request:
    - blockBase = addr with the low log2(BLOCK_WORDS)+2 bits cleared.
    - startIdx = addr[log2(BLOCK_WORDS)+1:2].
    - Go to WAIT if LATENCY>0, otherwise BURST.
  - WAIT: o_ready=0. A counter runs LATENCY cycles. The state moves to BURST on the edge where the counter reaches LATENCY-1.
  - BURST: o_ready=0. On each edge the registered outputs present beat k (k = 0..BLOCK_WORDS-1):
    - idx = (startIdx + k) mod BLOCK_WORDS (wraps inside the block and never crosses into the next block).
    - o_addr = blockBase + 4*idx.
  - After the edge presenting beat BLOCK_WORDS-1 (o_last=1), the next edge clears o_valid and returns to IDLE. o_ready is high the cycle after the last beat.
- Timing: request accepted at edge N. The first beat is valid in the cycle after edge N+1+LATENCY. Beats are back-to-back for BLOCK_WORDS cycles. There is no backpressure; the consumer must take every beat.
- Beat data:
  - word index w = o_addr[ADDR_WIDTH-1:2].
  - If w < MEM_WORDS: o_data = mem[w], o_err=0.
  - Otherwise: o_data=0, o_err=1 for that beat only.
- Loader writes: mem[i_wr_addr[..:2]] <= i_wr_data at the edge, allowed in any state. Writes to index >= MEM_WORDS are dropped. A write and a read of the same word at the same edge returns the old data.
- i_req while o_ready=0 is ignored; it is not queued.
- i_flush: in WAIT or BURST, the next edge forces IDLE with o_valid=o_last=o_err=0. It has no effect in IDLE and takes priority over beat generation. A request with i_flush=1 in IDLE is still accepted.
- Reset asserted mid-burst: outputs clear immediately (asynchronous), without waiting for a clock edge.
- Counters are sized log2 of their maximum plus 1 bit and never overflow. The o_addr adder is ADDR_WIDTH bits wide, with wrap at 2^ADDR_WIDTH.

Test Plan:
- Preload mem[0..7]=0x100..0x107, LATENCY=2, request addr 0x0 at edge 0 -> o_valid in cycles after edges 3..6, o_addr 0x0,0x4,0x8,0xC, o_data 0x100..0x103, o_last only on 0xC, o_ready=1 after edge 7.
- Request addr 0x18 (BLOCK_WORDS=4) -> beats at o_addr 0x18,0x1C,0x10,0x14 with o_data 0x106,0x107,0x104,0x105; o_last on 0x14.
- LATENCY=0, request 0x4 -> first beat (0x4, 0x101) in the cycle after edge 1; a second i_req during the burst is ignored and o_ready stays 0.
- Request 0xFFC with MEM_WORDS=1024 -> block 0xFF0..0xFFC all valid, o_err=0; request 0x1000 -> four beats with o_data=0, o_err=1.
- i_flush on the second beat -> o_valid=0 at the next edge, o_ready=1, no o_last seen; a new request to 0x8 then completes normally.
- Reset asserted mid-WAIT and mid-BURST -> o_valid/o_last/o_err fall to 0 and o_ready rises to 1 without a clock edge; a loader write of 0xDEAD to 0x0 during IDLE is returned on the next fill of 0x0.
